// File: rtl/ahb_arb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_arb_pkg
// Shared definitions for the AHB master arbiter and the bridge-side arbiter:
// the 2-bit arbitration state encoding and the transfer-completion rule.
// No ports (package).
// -----------------------------------------------------------------------------
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,  // no owner, arbitrating
      GRANT  = 2'd1,  // local slave owned by a master
      BREQ   = 2'd2,  // waiting for the bridge arbiter
      BRIDGE = 2'd3   // bridge-side slave owned by a master
   } arb_state_e;

   // A transfer completes only on a ready, non-error response.
   function automatic logic tr_done_f(input logic hready_out, input logic hresp);
      return hready_out & ~hresp;
   endfunction

endpackage

// File: rtl/ahb_arbiter_param_if.sv
// -----------------------------------------------------------------------------
// ahb_arbiter_param_if
// Request/grant bundle between the masters, the slave response path, the
// bridge arbiter and ahb_arbiter_param.
//   master modport : drives hreq, sel_in, hready_out, hresp, hgrantb;
//                    observes hreqb, hgrant, sel, owner, timeout
//   slave  modport : the arbiter side (directions mirrored)
// -----------------------------------------------------------------------------
interface ahb_arbiter_param_if #(
   parameter int NUM_MASTERS = 4,
   parameter int SEL_W       = 4,
   parameter int OWN_W       = $clog2(NUM_MASTERS)
);
   logic [NUM_MASTERS-1:0]       hreq;
   logic [NUM_MASTERS*SEL_W-1:0] sel_in;
   logic                         hready_out;
   logic                         hresp;
   logic                         hgrantb;
   logic                         hreqb;
   logic [NUM_MASTERS-1:0]       hgrant;
   logic [SEL_W-1:0]             sel;
   logic [OWN_W-1:0]             owner;
   logic                         timeout;

   modport master (
      output hreq, sel_in, hready_out, hresp, hgrantb,
      input  hreqb, hgrant, sel, owner, timeout
   );

   modport slave (
      input  hreq, sel_in, hready_out, hresp, hgrantb,
      output hreqb, hgrant, sel, owner, timeout
   );
endinterface

// File: rtl/ahb_arbiter_param_rr_pick.sv
// -----------------------------------------------------------------------------
// ahb_arbiter_param_rr_pick
// Combinational request picker.
//   req_i     : request vector
//   ptr_i     : index of the previous owner (round-robin start is ptr_i+1)
//   rr_mode_i : 1 = round-robin from ptr_i+1, 0 = fixed, index 0 highest
//   winner_o  : index of the selected request
//   valid_o   : at least one request is set
// -----------------------------------------------------------------------------
module ahb_arbiter_param_rr_pick #(
   parameter int NUM_MASTERS = 4,
   parameter int OWN_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [OWN_W-1:0]       ptr_i,
   input  logic                   rr_mode_i,
   output logic [OWN_W-1:0]       winner_o,
   output logic                   valid_o
);

   int               base;
   logic [OWN_W-1:0] idx;

   // NOTE: every variable assigned in always_comb gets a default first so
   // no path leaves it unassigned and a latch can never be inferred.
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = '0;
      base     = rr_mode_i ? int'(ptr_i) + 1 : 0;
      // Walk from the farthest offset back to the nearest so the request
      // closest to the start position is the last (winning) assignment.
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         idx = OWN_W'((base + k) % NUM_MASTERS);
         if (req_i[idx]) begin
            winner_o = idx;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter_param.sv
// -----------------------------------------------------------------------------
// ahb_arbiter_param
// N-master AHB arbiter with fixed or round-robin priority. Local transfers
// get a one-hot grant directly; transfers to a bridge-side slave first
// request the downstream bridge arbiter (hreqb/hgrantb). A hold counter
// forces release if the owner never completes. All outputs are registered.
//   hclk, hresetn : clock, asynchronous active-low reset
//   bus (slave)   : hreq, sel_in, hready_out, hresp, hgrantb in;
//                   hreqb, hgrant, sel, owner, timeout out
// -----------------------------------------------------------------------------
module ahb_arbiter_param
   import ahb_arb_pkg::*;
#(
   parameter int               NUM_MASTERS = 4,
   parameter int               SEL_W       = 4,
   parameter logic [SEL_W-1:0] BRIDGE_MASK = 4'b1100,
   parameter bit               RR_MODE     = 1'b1,
   parameter int               HOLD_MAX    = 256,
   parameter int               OWN_W       = $clog2(NUM_MASTERS)
) (
   input logic              hclk,
   input logic              hresetn,
   ahb_arbiter_param_if.slave bus
);

   localparam int               CNT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

   arb_state_e             state_q, state_d;
   logic [OWN_W-1:0]       owner_q, owner_d, ptr_q, ptr_d, winner;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
   logic                   hreqb_q, hreqb_d, timeout_q, timeout_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   win_valid, bridge_w, tr_done, expired, force_rel;
   logic [SEL_W-1:0]       sel_arr [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_sel_unpack
      assign sel_arr[i] = bus.sel_in[i*SEL_W +: SEL_W];
   end

   ahb_arbiter_param_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .OWN_W       (OWN_W)
   ) u_pick (
      .req_i     (bus.hreq),
      .ptr_i     (ptr_q),
      .rr_mode_i (RR_MODE),
      .winner_o  (winner),
      .valid_o   (win_valid)
   );

   // Bridge decode looks only at the winner's select.
   assign bridge_w = |(sel_arr[winner] & BRIDGE_MASK);
   assign tr_done  = tr_done_f(bus.hready_out, bus.hresp);
   assign expired  = (HOLD_MAX != 0) && (cnt_q == CNT_LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic. A completion on the last allowed cycle is a normal
   // release; force_rel marks only the timeout path.
   always_comb begin
      state_d   = state_q;
      force_rel = 1'b0;
      unique case (state_q)
         IDLE: if (win_valid) state_d = bridge_w ? BREQ : GRANT;
         GRANT, BRIDGE: begin
            if (tr_done) begin
               state_d = IDLE;
            end else if (expired) begin
               state_d   = IDLE;
               force_rel = 1'b1;
            end
         end
         BREQ: begin
            if (bus.hgrantb) begin
               state_d = BRIDGE;
            end else if (!bus.hreq[owner_q]) begin
               state_d = IDLE;  // requester gave up before the bridge answered
            end else if (expired) begin
               state_d   = IDLE;
               force_rel = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values, all derived from state_d.
   always_comb begin
      owner_d   = owner_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      hgrant_d  = '0;
      hreqb_d   = 1'b0;
      timeout_d = force_rel;
      cnt_d     = cnt_q;

      if (state_q == IDLE && win_valid) begin
         owner_d = winner;
         sel_d   = sel_arr[winner];
      end

      unique case (state_d)
         IDLE:   sel_d = '0;
         GRANT:  hgrant_d[owner_d] = 1'b1;
         BREQ:   hreqb_d = 1'b1;
         BRIDGE: begin
            hreqb_d           = bus.hreq[owner_d];
            hgrant_d[owner_d] = bus.hgrantb;
         end
         default: ;
      endcase

      // Only a served transfer advances the round-robin pointer; an aborted
      // bridge request leaves it where it was.
      if ((state_q == GRANT || state_q == BRIDGE) && state_d == IDLE)
         ptr_d = owner_q;

      if (state_d == IDLE || state_d != state_q) cnt_d = '0;
      else if (HOLD_MAX != 0)                    cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         owner_q   <= '0;
         sel_q     <= '0;
         ptr_q     <= OWN_W'(NUM_MASTERS - 1);  // master 0 wins first
         hgrant_q  <= '0;
         hreqb_q   <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         owner_q   <= owner_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         hgrant_q  <= hgrant_d;
         hreqb_q   <= hreqb_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.hgrant  = hgrant_q;
   assign bus.hreqb   = hreqb_q;
   assign bus.sel     = sel_q;
   assign bus.owner   = owner_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// -----------------------------------------------------------------------------
// tb_ahb_arbiter_param
// Directed bench: one fixed-priority and one round-robin arbiter (both with
// HOLD_MAX=8) on a shared clock and reset. Inputs change 1 time unit after
// the rising edge and outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_ahb_arbiter_param;

   logic hclk;
   logic hresetn;
   int   n_checks = 0;
   int   n_errors = 0;

   ahb_arbiter_param_if #(.NUM_MASTERS(4), .SEL_W(4)) if_fx ();
   ahb_arbiter_param_if #(.NUM_MASTERS(4), .SEL_W(4)) if_rr ();

   ahb_arbiter_param #(
      .NUM_MASTERS(4), .SEL_W(4), .BRIDGE_MASK(4'b1100), .RR_MODE(1'b0), .HOLD_MAX(8)
   ) dut_fx (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (if_fx)
   );

   ahb_arbiter_param #(
      .NUM_MASTERS(4), .SEL_W(4), .BRIDGE_MASK(4'b1100), .RR_MODE(1'b1), .HOLD_MAX(8)
   ) dut_rr (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (if_rr)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      hresetn = 1'b0;
      if_fx.hreq = '0; if_fx.sel_in = '0; if_fx.hready_out = 1'b0; if_fx.hresp = 1'b0; if_fx.hgrantb = 1'b0;
      if_rr.hreq = '0; if_rr.sel_in = '0; if_rr.hready_out = 1'b0; if_rr.hresp = 1'b0; if_rr.hgrantb = 1'b0;

      // Reset values
      #3;
      check("rst_hgrant",  if_fx.hgrant,  32'h0);
      check("rst_sel",     if_fx.sel,     32'h0);
      check("rst_hreqb",   if_fx.hreqb,   32'h0);
      check("rst_owner",   if_fx.owner,   32'h0);
      check("rst_timeout", if_fx.timeout, 32'h0);
      check("rst_rr_gnt",  if_rr.hgrant,  32'h0);
      step(); step();
      hresetn = 1'b1;

      // Fixed priority: 1010 -> master 1, then master 3 after one IDLE cycle
      if_fx.sel_in = 16'h1111;
      if_fx.hreq   = 4'b1010;
      step();
      check("fx_grant1", if_fx.hgrant, 32'b0010);
      check("fx_owner1", if_fx.owner,  32'd1);
      check("fx_sel1",   if_fx.sel,    32'h1);
      step();
      check("fx_hold1",  if_fx.hgrant, 32'b0010);
      if_fx.hready_out = 1'b1;
      if_fx.hreq       = 4'b1000;
      step();
      check("fx_idle",     if_fx.hgrant, 32'h0);
      check("fx_idle_sel", if_fx.sel,    32'h0);
      if_fx.hready_out = 1'b0;
      step();
      check("fx_grant3", if_fx.hgrant, 32'b1000);
      check("fx_owner3", if_fx.owner,  32'd3);
      if_fx.hready_out = 1'b1;
      if_fx.hreq       = '0;
      step();
      check("fx_rel3", if_fx.hgrant, 32'h0);
      if_fx.hready_out = 1'b0;

      // Round-robin with all requesting: 0,1,2,3,0 with an IDLE gap each time
      if_rr.sel_in     = 16'h1111;
      if_rr.hreq       = 4'b1111;
      if_rr.hready_out = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("rr_grant", if_rr.hgrant, 32'(1 << (k % 4)));
         step();
         check("rr_gap",   if_rr.hgrant, 32'h0);
      end
      if_rr.hreq       = '0;
      if_rr.hready_out = 1'b0;

      // Bridge path: master 2 selects a bridge slave (pointer is 0)
      if_rr.sel_in = 16'h1411;
      if_rr.hreq   = 4'b0100;
      step();
      check("br_hreqb", if_rr.hreqb,  32'h1);
      check("br_nognt", if_rr.hgrant, 32'h0);
      check("br_owner", if_rr.owner,  32'd2);
      step(); step();
      check("br_wait_hreqb", if_rr.hreqb,  32'h1);
      check("br_wait_nognt", if_rr.hgrant, 32'h0);
      if_rr.hgrantb = 1'b1;
      step();
      check("br_grant",        if_rr.hgrant, 32'b0100);
      check("br_sel",          if_rr.sel,    32'b0100);
      check("br_hreqb_bridge", if_rr.hreqb,  32'h1);
      if_rr.hready_out = 1'b1;
      step();
      check("br_rel_gnt",   if_rr.hgrant, 32'h0);
      check("br_rel_hreqb", if_rr.hreqb,  32'h0);
      check("br_rel_sel",   if_rr.sel,    32'h0);
      if_rr.hready_out = 1'b0;
      if_rr.hgrantb    = 1'b0;
      if_rr.hreq       = '0;

      // Aborted bridge request by master 0 (pointer stays at 2)
      if_rr.sel_in = 16'h1114;
      if_rr.hreq   = 4'b0001;
      step();
      check("ab_hreqb", if_rr.hreqb, 32'h1);
      check("ab_owner", if_rr.owner, 32'd0);
      if_rr.hreq = '0;
      step();
      check("ab_idle_hreqb", if_rr.hreqb,  32'h0);
      check("ab_idle_gnt",   if_rr.hgrant, 32'h0);
      if_rr.sel_in = 16'h1111;
      if_rr.hreq   = 4'b1011;
      step();
      check("ab_ptr_grant", if_rr.hgrant, 32'b1000);
      check("ab_ptr_owner", if_rr.owner,  32'd3);
      if_rr.hready_out = 1'b1;
      if_rr.hreq       = '0;
      step();
      check("ab_rel", if_rr.hgrant, 32'h0);
      if_rr.hready_out = 1'b0;

      // Hold timeout: master 0 never completes, held 8 cycles then forced off
      if_rr.hreq = 4'b0011;
      step();
      check("to_grant", if_rr.hgrant, 32'b0001);
      for (int k = 0; k < 7; k++) begin
         step();
         check("to_hold",  if_rr.hgrant,  32'b0001);
         check("to_quiet", if_rr.timeout, 32'h0);
      end
      step();
      check("to_release", if_rr.hgrant,  32'h0);
      check("to_pulse",   if_rr.timeout, 32'h1);
      step();
      check("to_next",      if_rr.hgrant,  32'b0010);
      check("to_pulse_end", if_rr.timeout, 32'h0);
      // Completion on the last allowed cycle is a normal release
      for (int k = 0; k < 7; k++) begin
         step();
         check("tl_hold", if_rr.hgrant, 32'b0010);
      end
      if_rr.hready_out = 1'b1;
      step();
      check("tl_release",    if_rr.hgrant,  32'h0);
      check("tl_no_timeout", if_rr.timeout, 32'h0);
      if_rr.hready_out = 1'b0;
      if_rr.hreq       = '0;

      // Error responses are not completion; dropping hreq does not release
      if_fx.hreq = 4'b0100;
      step();
      check("er_grant", if_fx.hgrant, 32'b0100);
      if_fx.hreq       = '0;
      if_fx.hready_out = 1'b1;
      if_fx.hresp      = 1'b1;
      step();
      check("er_hold1", if_fx.hgrant, 32'b0100);
      step();
      check("er_hold2", if_fx.hgrant, 32'b0100);
      if_fx.hresp = 1'b0;
      step();
      check("er_release", if_fx.hgrant, 32'h0);
      if_fx.hready_out = 1'b0;

      // Reset in the middle of a grant (pointer is 1 -> master 2 wins)
      if_rr.hreq = 4'b1111;
      step();
      check("rs_grant", if_rr.hgrant, 32'b0100);
      check("rs_owner", if_rr.owner,  32'd2);
      #2;
      hresetn = 1'b0;
      #1;
      check("rs_async_gnt",   if_rr.hgrant, 32'h0);
      check("rs_async_sel",   if_rr.sel,    32'h0);
      check("rs_async_hreqb", if_rr.hreqb,  32'h0);
      step();
      hresetn = 1'b1;
      step();
      check("rs_first_gnt",   if_rr.hgrant, 32'b0001);
      check("rs_first_owner", if_rr.owner,  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
